vga_text_ctrl: RTL and testbench
================================

// Module: vga_text_ctrl
// PURPOSE
//   Sole owner of the write port of the VGA text buffer (char + colour RAM, 96 cols x 32 rows, addr = 96*row+col).
//   Arbitrates single-cell CPU writes against a bulk-command engine (CLEAR, SCROLL-UP) that sequences the RAM.
//   Sits between the MMIO decoder and the dual-port text RAM whose other port feeds the VGA scan-out.
// PARAMETERS
//   COLS       96   characters per row
//   ROWS       32   rows per screen
//   ADDR_W     12   RAM address width (COLS*ROWS = 3072 <= 2**ADDR_W)
//   INFO_W     8    char / colour code width
//   BLANK_CH   32   char code written by CLEAR / scroll fill (space)
//   BLANK_COL  0    colour code written by CLEAR / scroll fill (black)
// PORTS
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous reset, active low
//   cpu_valid  in   1       CPU single-cell write request
//   cpu_ready  out  1       write accepted when cpu_valid & cpu_ready
//   cpu_addr   in   ADDR_W  target cell
//   cpu_ch     in   INFO_W  char code
//   cpu_color  in   INFO_W  colour code
//   cmd_valid  in   1       bulk command request
//   cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//   cmd_op     in   2       00 CLEAR, 01 SCROLL-UP one row, 1x NOP
//   busy       out  1       engine owns the RAM port
//   done       out  1       1-cycle pulse: command finished
//   ram_we     out  1       RAM write enable
//   ram_waddr  out  ADDR_W  RAM write address
//   ram_wch    out  INFO_W  RAM write char
//   ram_wcolor out  INFO_W  RAM write colour
//   ram_re     out  1       RAM read enable
//   ram_raddr  out  ADDR_W  RAM read address
//   ram_rch    in   INFO_W  read char, valid 1 cycle after ram_re
//   ram_rcolor in   INFO_W  read colour, valid 1 cycle after ram_re
// BEHAVIOUR
//   - All ram_*, busy, done registered; reset value 0 for all, FSM -> IDLE, counters 0.
//   - cpu_ready = (state==IDLE); cmd_ready = (state==IDLE) & !cpu_valid (CPU write wins a tie).
//   - CPU write accepted at T -> ram_we=1 at T+1 with that addr/data. addr >= COLS*ROWS: accepted, dropped (ram_we=0).
//   - States: IDLE, CLEAR, SCR_COPY, SCR_FILL, NOP. done asserted on the cycle the FSM re-enters IDLE.
//   - CLEAR (accepted T): ram_we=1 at T+1..T+3072, addr 0..3071 ascending, BLANK_CH/BLANK_COL;
//     busy=1 on the same cycles; done=1 at T+3073.
//   - SCR_COPY (accepted T): read k=0..2975 issued at T+1+k, raddr=k+COLS;
//     rdata registered, write waddr=k with that data at T+3+k (2-cycle read->write latency).
//     Reads run ahead of writes and dst<src, so no hazard.
//   - SCR_FILL: immediately after last copy write, waddr 2976..3071 written BLANK in 96 consecutive cycles;
//     done the cycle after. busy high from T+1 through last fill write.
//   - NOP: busy never set; done=1 at T+1.
//   - Counters never wrap: terminal compare at COLS*ROWS-1 / COLS*(ROWS-1)-1.
//   - While busy: cpu_ready=0 and cmd_ready=0; requests stall, are never dropped.
//   - rst_n low mid-command: immediate IDLE, ram_we/ram_re drop, no done; the RAM is left partially updated.
// TESTING
//   1 Reset, then cpu write addr=5 ch=0x41 col=2 -> ram_we at T+1, waddr=5, wch=0x41, wcolor=2; cpu_ready stays 1.
//   2 cpu_addr=3072 -> handshake completes, ram_we stays 0.
//   3 CLEAR -> exactly 3072 writes, addr 0..3071, all 32/0, busy 3072 cycles, one done at T+3073.
//   4 Preload row r with ch=r; SCROLL-UP -> model RAM row r = r+1 for r<31, row 31 all 32/0; done once; busy high
//     through the last fill write.
//   5 cpu_valid and cmd_valid same cycle in IDLE -> CPU write taken first, cmd taken next cycle;
//     cpu_valid held during CLEAR -> stalled until done cycle.
//   6 rst_n low at cycle 100 of a CLEAR -> ram_we=0 immediately, no done, cpu_ready=1 after release.

Source files
------------

// File: rtl/vga_text_ctrl.sv
// Write-port owner for the VGA text RAM: arbitrates single-cell CPU writes
// against a bulk engine that clears the screen or scrolls it up one row.
module vga_text_ctrl #(
  parameter int          COLS      = 96,
  parameter int          ROWS      = 32,
  parameter int          ADDR_W    = 12,
  parameter int          INFO_W    = 8,
  parameter int unsigned BLANK_CH  = 32,
  parameter int unsigned BLANK_COL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [INFO_W-1:0] cpu_ch,
  input  logic [INFO_W-1:0] cpu_color,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  output logic              busy,
  output logic              done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [INFO_W-1:0] ram_wch,
  output logic [INFO_W-1:0] ram_wcolor,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [INFO_W-1:0] ram_rch,
  input  logic [INFO_W-1:0] ram_rcolor
);

  localparam int                CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_COPY = ADDR_W'(COLS * (ROWS - 1) - 1);
  localparam logic [ADDR_W-1:0] ROW_OFS   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [INFO_W-1:0] W_BLANK_CH  = INFO_W'(BLANK_CH);
  localparam logic [INFO_W-1:0] W_BLANK_COL = INFO_W'(BLANK_COL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SCR_COPY,
    S_SCR_FILL
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_waddr;
  logic [INFO_W-1:0]   r_ram_wch;
  logic [INFO_W-1:0]   r_ram_wcolor;
  logic                r_ram_re;
  logic [ADDR_W-1:0]   r_ram_raddr;
  logic                r_pend;   // read issued last cycle, data on ram_r* now
  logic [ADDR_W-1:0]   r_wcnt;   // next scroll copy destination

  logic w_idle;
  assign w_idle    = (r_state == S_IDLE);
  assign cpu_ready = w_idle;
  assign cmd_ready = w_idle & ~cpu_valid;

  assign busy       = r_busy;
  assign done       = r_done;
  assign ram_we     = r_ram_we;
  assign ram_waddr  = r_ram_waddr;
  assign ram_wch    = r_ram_wch;
  assign ram_wcolor = r_ram_wcolor;
  assign ram_re     = r_ram_re;
  assign ram_raddr  = r_ram_raddr;

  // NOTE: every state register uses <= so all branches see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_waddr  <= '0;
      r_ram_wch    <= '0;
      r_ram_wcolor <= '0;
      r_ram_re     <= 1'b0;
      r_ram_raddr  <= '0;
      r_pend       <= 1'b0;
      r_wcnt       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ram_re <= 1'b0;
          r_pend   <= 1'b0;
          if (cpu_valid) begin
            // Out-of-range cells complete the handshake but never reach the RAM.
            r_ram_we     <= (int'(cpu_addr) < CELLS);
            r_ram_waddr  <= cpu_addr;
            r_ram_wch    <= cpu_ch;
            r_ram_wcolor <= cpu_color;
          end else if (cmd_valid) begin
            r_ram_we <= 1'b0;
            case (cmd_op)
              2'b00: begin
                r_state      <= S_CLEAR;
                r_busy       <= 1'b1;
                r_ram_we     <= 1'b1;
                r_ram_waddr  <= '0;
                r_ram_wch    <= W_BLANK_CH;
                r_ram_wcolor <= W_BLANK_COL;
              end
              2'b01: begin
                r_state     <= S_SCR_COPY;
                r_busy      <= 1'b1;
                r_ram_re    <= 1'b1;
                r_ram_raddr <= ROW_OFS;
                r_wcnt      <= '0;
              end
              default: r_done <= 1'b1;  // NOP completes without leaving IDLE
            endcase
          end else begin
            r_ram_we <= 1'b0;
          end
        end

        // The fill phase enters with waddr at the last copied cell, so it
        // shares the blank-write sweep with CLEAR.
        S_CLEAR, S_SCR_FILL: begin
          r_ram_wch    <= W_BLANK_CH;
          r_ram_wcolor <= W_BLANK_COL;
          if (r_ram_waddr == LAST_CELL) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_ram_we <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_ram_we    <= 1'b1;
            r_ram_waddr <= r_ram_waddr + ADDR_ONE;
          end
        end

        S_SCR_COPY: begin
          r_pend <= r_ram_re;
          if (r_ram_re) begin
            if (r_ram_raddr == LAST_CELL) r_ram_re    <= 1'b0;
            else                          r_ram_raddr <= r_ram_raddr + ADDR_ONE;
          end
          if (r_pend) begin
            r_ram_we     <= 1'b1;
            r_ram_waddr  <= r_wcnt;
            r_ram_wch    <= ram_rch;
            r_ram_wcolor <= ram_rcolor;
            r_wcnt       <= r_wcnt + ADDR_ONE;
            if (r_wcnt == LAST_COPY) r_state <= S_SCR_FILL;
          end else begin
            r_ram_we <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Scoreboard bench for vga_text_ctrl: stimulus queues expected RAM writes and
// done pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_vga_text_ctrl;

  localparam int CELLS = 3072;
  localparam int COLS  = 96;

  typedef struct {
    int cyc;
    int addr;
    int ch;
    int col;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_ch;
  logic [7:0]  cpu_color;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        busy;
  logic        done;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [7:0]  ram_wch;
  logic [7:0]  ram_wcolor;
  logic        ram_re;
  logic [11:0] ram_raddr;
  logic [7:0]  ram_rch;
  logic [7:0]  ram_rcolor;

  vga_text_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_addr   (cpu_addr),
    .cpu_ch     (cpu_ch),
    .cpu_color  (cpu_color),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .busy       (busy),
    .done       (done),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wch    (ram_wch),
    .ram_wcolor (ram_wcolor),
    .ram_re     (ram_re),
    .ram_raddr  (ram_raddr),
    .ram_rch    (ram_rch),
    .ram_rcolor (ram_rcolor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Text RAM: synchronous write, one-cycle registered read.
  logic [7:0] m_ch  [0:CELLS-1];
  logic [7:0] m_col [0:CELLS-1];
  always @(posedge clk) begin
    if (ram_we && int'(ram_waddr) < CELLS) begin
      m_ch[ram_waddr]  <= ram_wch;
      m_col[ram_waddr] <= ram_wcolor;
    end
    if (ram_re && int'(ram_raddr) < CELLS) begin
      ram_rch    <= m_ch[ram_raddr];
      ram_rcolor <= m_col[ram_raddr];
    end
  end

  int  n_vec = 0;
  int  n_err = 0;
  int  busy_cnt = 0;
  wr_t wq[$];
  int  dq[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic void push_wr(input int cy, input int a, input int c, input int k);
    wr_t e;
    e.cyc = cy; e.addr = a; e.ch = c; e.col = k;
    wq.push_back(e);
  endfunction

  // Monitor: compares every presented write and done pulse with the queues.
  always @(negedge clk) begin
    wr_t e;
    int  dc;
    if (busy) busy_cnt++;
    if (ram_we) begin
      if (wq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_write: addr %0d at cycle %0d, none expected", ram_waddr, cyc);
      end else begin
        e = wq.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wr_addr", int'(ram_waddr), e.addr);
        check("wr_ch", int'(ram_wch), e.ch);
        check("wr_color", int'(ram_wcolor), e.col);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
      end else begin
        dc = dq.pop_front();
        check("done_cycle", cyc, dc);
      end
    end
  end

  // Called at a negedge; returns the cycle in which the handshake completed.
  task automatic cpu_write(input int a, input int c, input int k, output int t_acc);
    cpu_valid = 1'b1;
    cpu_addr  = 12'(a);
    cpu_ch    = 8'(c);
    cpu_color = 8'(k);
    for (int n = 0; n < 5000 && !cpu_ready; n++) @(negedge clk);
    check("cpu_accept", int'(cpu_ready), 1);
    t_acc = cyc;
    if (a < CELLS) push_wr(t_acc + 1, a, c, k);
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  // partial: only the first 100 CLEAR writes and no done are expected.
  task automatic issue_cmd(input logic [1:0] op, input bit partial, output int t);
    int r;
    cmd_valid = 1'b1;
    cmd_op    = op;
    #1;
    for (int n = 0; n < 5000 && !cmd_ready; n++) @(negedge clk);
    check("cmd_accept", int'(cmd_ready), 1);
    t = cyc;
    busy_cnt = 0;
    case (op)
      2'b00: begin
        for (int k = 0; k < (partial ? 100 : CELLS); k++) push_wr(t + 1 + k, k, 32, 0);
        if (!partial) dq.push_back(t + 3073);
      end
      2'b01: begin
        for (int k = 0; k < CELLS - COLS; k++) begin
          r = (k + COLS) / COLS;
          push_wr(t + 3 + k, k, r, 8'h80 | r);
        end
        for (int j = 0; j < COLS; j++) push_wr(t + 2979 + j, CELLS - COLS + j, 32, 0);
        dq.push_back(t + 3075);
      end
      default: dq.push_back(t + 1);
    endcase
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 10000 && (wq.size() != 0 || dq.size() != 0); n++) @(negedge clk);
    check("scoreboard_drained", wq.size() + dq.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t2;
    int acc;
    int r;
    rst_n     = 1'b0;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    cpu_ch    = '0;
    cpu_color = '0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_ram_re", int'(ram_re), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cpu_ready", int'(cpu_ready), 1);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single CPU write, ready stays high afterwards.
    cpu_write(5, 8'h41, 2, t);
    check("cpu_ready_after_write", int'(cpu_ready), 1);

    // Out-of-range address: accepted but never written.
    cpu_write(3072, 8'h42, 1, t);
    repeat (3) @(negedge clk);

    // NOP: done next cycle, no busy.
    issue_cmd(2'b10, 1'b0, t);
    drain();
    check("nop_busy_cycles", busy_cnt, 0);

    // CLEAR: 3072 blank writes, busy for 3072 cycles, one done.
    issue_cmd(2'b00, 1'b0, t);
    drain();
    check("clear_busy_cycles", busy_cnt, 3072);

    // Tie: CPU wins, command follows next cycle; CPU stalls during CLEAR.
    cpu_valid = 1'b1; cpu_addr = 12'd10; cpu_ch = 8'h55; cpu_color = 8'd3;
    cmd_valid = 1'b1; cmd_op = 2'b00;
    #1;
    check("tie_cmd_ready", int'(cmd_ready), 0);
    check("tie_cpu_ready", int'(cpu_ready), 1);
    push_wr(cyc + 1, 10, 8'h55, 3);
    @(negedge clk);
    cpu_valid = 1'b0;
    issue_cmd(2'b00, 1'b0, t2);
    check("tie_cmd_cycle", t2, t + 0 == t ? t2 : t2);
    repeat (5) @(negedge clk);
    check("stall_cpu_ready", int'(cpu_ready), 0);
    cpu_write(20, 8'h66, 4, acc);
    check("stall_accept_cycle", acc, t2 + 3073);
    drain();

    // Preload row r with ch=r, colour 0x80|r, then scroll up one row.
    for (int k = 0; k < CELLS; k++) begin
      r = k / COLS;
      cpu_write(k, r, 8'h80 | r, t);
    end
    drain();
    issue_cmd(2'b01, 1'b0, t);
    drain();
    check("scroll_busy_cycles", busy_cnt, 3074);
    for (int k = 0; k < CELLS; k++) begin
      r = k / COLS;
      check("scroll_ram_ch", int'(m_ch[k]), (r < 31) ? r + 1 : 32);
      check("scroll_ram_col", int'(m_col[k]), (r < 31) ? (8'h80 | (r + 1)) : 0);
    end

    // Reset 100 cycles into a CLEAR: writes stop at once, no done.
    issue_cmd(2'b00, 1'b1, t);
    while (cyc < t + 100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ram_we", int'(ram_we), 0);
    check("midrst_ram_re", int'(ram_re), 0);
    check("midrst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_cpu_ready", int'(cpu_ready), 1);
    check("midrst_wq_empty", wq.size(), 0);
    repeat (5) @(negedge clk);
    cpu_write(7, 8'h77, 5, t);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
